// File: rtl/shift_add_controller.sv
// ---------------------------------------------------------------------------
// shift_add_controller
//
// Sequencer for an N-bit shift-and-add multiplier. The datapath (B, Q, A
// registers, adder and carry flop C) lives outside this block; this block
// only issues register controls, one step at a time.
//
// Register control encoding (ctrl_b / ctrl_q / ctrl_a):
//   11 load, 10 shift-left, 01 shift-right, 00 hold
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start, all controls quiet
// LOAD   | load B and Q operands, clear A and C, reset iteration index
// EVAL   | if Q LSB is set, A <= A + B and capture the carry into C
// SHIFT  | shift {C, A, Q} right by one, clear C, advance iteration
// DONE   | one-cycle completion pulse, product available in {A, Q}
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-high reset
//   start   begin one multiplication (accepted in IDLE only)
//   q0      current LSB of the Q register (used in EVAL only)
//   ctrl_b  B register control
//   ctrl_q  Q register control
//   ctrl_a  A register control
//   a_sel   A parallel-input select: 0 = zero, 1 = adder sum
//   c_load  capture adder carry-out into C
//   c_clr   clear C
//   busy    high whenever not in IDLE
//   done    one-cycle completion pulse
//   iter    current iteration index, 0 .. N-1
// ---------------------------------------------------------------------------
module shift_add_controller #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 q0,
    output logic [1:0]           ctrl_b,
    output logic [1:0]           ctrl_q,
    output logic [1:0]           ctrl_a,
    output logic                 a_sel,
    output logic                 c_load,
    output logic                 c_clr,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] iter
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] ITER_LAST = IW'(N - 1);

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHR  = 2'b01;
    localparam logic [1:0] CTRL_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                iter_d  = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (iter_q == ITER_LAST) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ctrl_b = CTRL_HOLD;
        ctrl_q = CTRL_HOLD;
        ctrl_a = CTRL_HOLD;
        a_sel  = 1'b0;
        c_load = 1'b0;
        c_clr  = 1'b0;
        done   = 1'b0;
        case (state_q)
            S_LOAD: begin
                ctrl_b = CTRL_LOAD;
                ctrl_q = CTRL_LOAD;
                ctrl_a = CTRL_LOAD;   // a_sel = 0 loads zero into A
                c_clr  = 1'b1;
            end
            S_EVAL: begin
                // q0 is the only input that reaches the outputs, and only here
                if (q0) begin
                    ctrl_a = CTRL_LOAD;
                    a_sel  = 1'b1;
                    c_load = 1'b1;
                end
            end
            S_SHIFT: begin
                // C enters A MSB and A LSB enters Q MSB through datapath wiring;
                // C is cleared on the same edge it is consumed.
                ctrl_a = CTRL_SHR;
                ctrl_q = CTRL_SHR;
                c_clr  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign iter = iter_q;

endmodule

// File: tb/tb_shift_add_controller.sv
module tb_shift_add_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       q0;
    logic [1:0] ctrl_b, ctrl_q, ctrl_a;
    logic       a_sel, c_load, c_clr, busy, done;
    logic [2:0] iter;

    logic       start4;
    logic       q0_4;
    logic [1:0] ctrl_b4, ctrl_q4, ctrl_a4;
    logic       a_sel4, c_load4, c_clr4, busy4, done4;
    logic [1:0] iter4;

    int errors = 0;
    int checks = 0;

    // external datapath for the N=8 instance
    logic [7:0] op_b, op_q;
    logic [7:0] mb, mq, ma;
    logic       mc;
    logic [8:0] sum;
    logic       noise_en;
    logic       q0_noise;

    assign sum = {1'b0, ma} + {1'b0, mb};
    assign q0  = noise_en ? q0_noise : mq[0];

    shift_add_controller #(.N(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .q0(q0),
        .ctrl_b(ctrl_b), .ctrl_q(ctrl_q), .ctrl_a(ctrl_a),
        .a_sel(a_sel), .c_load(c_load), .c_clr(c_clr),
        .busy(busy), .done(done), .iter(iter)
    );

    shift_add_controller #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .q0(q0_4),
        .ctrl_b(ctrl_b4), .ctrl_q(ctrl_q4), .ctrl_a(ctrl_a4),
        .a_sel(a_sel4), .c_load(c_load4), .c_clr(c_clr4),
        .busy(busy4), .done(done4), .iter(iter4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb <= '0; mq <= '0; ma <= '0; mc <= 1'b0;
        end else begin
            if (ctrl_b == 2'b11) mb <= op_b;
            case (ctrl_q)
                2'b11:   mq <= op_q;
                2'b01:   mq <= {ma[0], mq[7:1]};
                default: ;
            endcase
            case (ctrl_a)
                2'b11:   ma <= a_sel ? sum[7:0] : 8'h00;
                2'b01:   ma <= {mc, ma[7:1]};
                default: ;
            endcase
            if (c_clr)       mc <= 1'b0;
            else if (c_load) mc <= sum[8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full multiplication; cycle 0 is the IDLE cycle in which start is seen.
    task automatic run_op(input logic [7:0] b, input logic [7:0] q, input bit noise);
        logic [15:0] exp_p;
        exp_p    = 16'(b) * 16'(q);
        op_b     = b;
        op_q     = q;
        noise_en = noise;
        q0_noise = 1'($urandom);
        start    = 1'b1;
        #1;
        check("idle_busy", 32'(busy), 0);
        step();
        start    = 1'b0;
        q0_noise = 1'($urandom);
        check("load_ctrl", {ctrl_b, ctrl_q, ctrl_a, a_sel, c_clr, busy}, 32'b11_11_11_0_1_1);
        for (int i = 0; i < 8; i++) begin
            step();
            noise_en = 1'b0;
            #1;
            check("eval_c_load", 32'(c_load), 32'(q[i]));
            check("eval_ctrl_a", 32'(ctrl_a), q[i] ? 32'd3 : 32'd0);
            check("eval_iter", 32'(iter), i);
            check("eval_ctrl_bq", {ctrl_b, ctrl_q, done}, 0);
            step();
            noise_en = noise;
            q0_noise = 1'($urandom);
            #1;
            check("shift_ctrl", {ctrl_b, ctrl_q, ctrl_a, c_clr, c_load}, 32'b00_01_01_1_0);
        end
        step();
        check("done_pulse", {done, busy}, 2'b11);
        check("product", {ma, mq}, 32'(exp_p));
        step();
        noise_en = 1'b0;
        check("after_done", {done, busy}, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start4 = 1'b0; q0_4 = 1'b0;
        op_b = '0; op_q = '0; noise_en = 1'b0; q0_noise = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_outputs", {ctrl_b, ctrl_q, ctrl_a, a_sel, c_load, c_clr, busy, done}, 0);
        check("rst_iter", 32'(iter), 0);
        check("rst_outputs4", {busy4, done4, iter4}, 0);
        step();
        rst = 1'b0;
        step();
        check("idle_after_rst", {busy, done}, 0);

        // multiplier 0xA5: c_load in iterations 0,2,5,7, done in cycle 18
        run_op(8'h37, 8'hA5, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);
        run_op(8'h0D, 8'h0B, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_op(8'($urandom), 8'($urandom), 1'b1);
        end
        // Q=0 with q0 noise outside EVAL: c_load must stay low throughout
        run_op(8'($urandom), 8'h00, 1'b1);

        // start held high: done every 19 cycles, never restarted while busy
        start = 1'b1;
        #1;
        for (int c = 0; c < 57; c++) begin
            check("held_busy", 32'(busy), (c % 19 != 0) ? 32'd1 : 32'd0);
            check("held_done", 32'(done), (c % 19 == 18) ? 32'd1 : 32'd0);
            step();
        end
        start = 1'b0;
        step();
        step();
        check("held_stop", {busy, done}, 0);

        // reset during SHIFT of iteration 3 (cycle 9)
        op_b  = 8'($urandom);
        op_q  = 8'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 9; c++) step();
        check("pre_rst_shift", {ctrl_a, iter}, {2'b01, 3'd3});
        #1 rst = 1'b1;
        #1;
        check("mid_rst_outputs", {ctrl_b, ctrl_q, ctrl_a, a_sel, c_load, c_clr, busy, done}, 0);
        check("mid_rst_iter", 32'(iter), 0);
        #1 rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step();
            check("no_op_after_rst", {busy, done}, 0);
        end

        // N=4 instance: iter 0,0,1,1,2,2,3,3 over cycles 2..9, done in 10
        start4 = 1'b1;
        #1;
        for (int c = 0; c <= 11; c++) begin
            q0_4 = 1'($urandom);
            #1;
            if (c >= 2 && c <= 9) check("n4_iter", 32'(iter4), (c - 2) / 2);
            check("n4_done", 32'(done4), (c == 10) ? 32'd1 : 32'd0);
            step();
            start4 = 1'b0;
        end
        check("n4_idle", {busy4, done4}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
